// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: one word read per start, req/ready handshake,
// flush handling while a read is outstanding.
// Optional memory timeout enabled by defining INSTR_FETCH_TIMEOUT_EN.
module instr_fetch #(
    parameter logic [31:0] RESET_INSTR    = 32'h00000013,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        start,
    input  logic        flush,
    input  logic [31:0] pc_in,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        misalign,
    output logic        fetch_err,
    output logic        busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]  state, state_nxt;
    logic        mem_req_nxt;
    logic [31:0] mem_addr_nxt;
    logic [31:0] instr_nxt;
    logic        instr_valid_nxt;
    logic        misalign_nxt;
    logic        fetch_err_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic        timeout_c;

`ifdef INSTR_FETCH_TIMEOUT_EN
    // Timeout fires on the cycle the counter would reach TIMEOUT_CYCLES.
    assign timeout_c = (cnt == 16'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;
    assign unused_timeout = ^{16'(TIMEOUT_CYCLES), cnt};
    assign timeout_c = 1'b0;
`endif

    // State and registered outputs.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state       <= S_IDLE;
            mem_req     <= 1'b0;
            mem_addr    <= 32'h0;
            instr       <= RESET_INSTR;
            instr_valid <= 1'b0;
            misalign    <= 1'b0;
            fetch_err   <= 1'b0;
            busy        <= 1'b0;
            cnt         <= 16'h0;
        end else begin
            state       <= state_nxt;
            mem_req     <= mem_req_nxt;
            mem_addr    <= mem_addr_nxt;
            instr       <= instr_nxt;
            instr_valid <= instr_valid_nxt;
            misalign    <= misalign_nxt;
            fetch_err   <= fetch_err_nxt;
            busy        <= (state_nxt != S_IDLE);
            cnt         <= cnt_nxt;
        end
    end

    // Next-state and next-output logic; pulses default low.
    always_comb begin
        state_nxt       = state;
        mem_req_nxt     = mem_req;
        mem_addr_nxt    = mem_addr;
        instr_nxt       = instr;
        instr_valid_nxt = 1'b0;
        misalign_nxt    = 1'b0;
        fetch_err_nxt   = 1'b0;
        cnt_nxt         = cnt;
        case (state)
            S_IDLE: begin
                if (start && !flush) begin
                    if (pc_in[1:0] != 2'b00) begin
                        misalign_nxt = 1'b1;
                    end else begin
                        mem_addr_nxt = pc_in;
                        mem_req_nxt  = 1'b1;
                        cnt_nxt      = 16'h0;
                        state_nxt    = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_nxt = cnt + 16'd1;
                if (mem_ready) begin
                    mem_req_nxt = 1'b0;
                    state_nxt   = S_IDLE;
                    if (!flush) begin
                        instr_nxt       = mem_rdata;
                        instr_valid_nxt = 1'b1;
                    end
                end else if (timeout_c) begin
                    fetch_err_nxt = 1'b1;
                    mem_req_nxt   = 1'b0;
                    state_nxt     = S_IDLE;
                end else if (flush) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                cnt_nxt = cnt + 16'd1;
                if (mem_ready) begin
                    mem_req_nxt = 1'b0;
                    state_nxt   = S_IDLE;
                end else if (timeout_c) begin
                    fetch_err_nxt = 1'b1;
                    mem_req_nxt   = 1'b0;
                    state_nxt     = S_IDLE;
                end
            end
            default: begin
                mem_req_nxt = 1'b0;
                state_nxt   = S_IDLE;
            end
        endcase
    end

endmodule
